fmt_print_engine: RTL and testbench
===================================

# fmt_print_engine

Hardware counterpart of the `$display`/`$write`/`$monitor` task family and its `b`/`o`/`h` radix variants. The block renders up to `NUM_CH` parallel data channels as an ASCII character stream in binary, octal or hex, once per command or continuously on value change. Its output is a valid/ready byte stream that feeds a UART or trace FIFO on the debug path.

## Interface
Parameters:
- `DATA_W`, 32: width of each channel, 1..64.
- `NUM_CH`, 4: number of channels, 1..8.
- `SEP_CHAR`, 8'h20: separator emitted between channels.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ch_data`  in  `NUM_CH*DATA_W`  channel values; channel i at `[i*DATA_W +: DATA_W]`.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_mode`  in  2  00 display, 01 write, 10 monitor-arm, 11 monitor-off.
- `cmd_radix`  in  2  00 hex, 01 bin, 10 oct, 11 hex.
- `cmd_ch_mask`  in  `NUM_CH`  channels to print.
- `out_valid`  out  1  `out_char` is valid.
- `out_ready`  in  1  downstream accepts the character.
- `out_char`  out  8  ASCII character.
- `busy`  out  1  a stream is in progress.
- `mon_armed`  out  1  monitor mode is active.

## Operation
- Digit count: D = ceil(`DATA_W`/b), where b = 1, 3 or 4 bits per digit.
- Digits are emitted MSB-first with leading zeros kept. The top octal or hex digit is zero-extended.
- Hex digits use lowercase `0-9a-f`.
- Record format: the enabled channels in ascending index order, with `SEP_CHAR` between channels and no trailing separator.
- Display and monitor records end with 8'h0A. Write records do not.
- Snapshot: all channels are captured into a print register on the accept cycle. Later changes to `ch_data` do not affect a stream in progress.
- Display and write: the stream is emitted once, then the block returns to IDLE.
- Monitor-arm:
  - Sets `mon_armed` and stores mask and radix in the monitor config.
  - Prints one record immediately.
  - Stores the printed values as the monitor reference.
- Monitor trigger: while armed and in IDLE, any masked channel that differs from the monitor reference causes a capture and a print record, and the reference is updated.
- Monitor-off: clears `mon_armed` and emits nothing. Re-arming replaces the config.
- Mask all-zero:
  - Display emits only 8'h0A.
  - Write emits nothing and returns to IDLE the next cycle.
  - Monitor-arm with a zero mask arms the monitor but never triggers.
- State machine: IDLE -> DIGIT -> (SEP -> DIGIT)* -> NL -> IDLE. Write skips NL. Every state except IDLE holds until its character handshakes.
- `cmd_ready` = (state == IDLE).
- `busy` = !IDLE.
- Simultaneous user command and monitor trigger in IDLE: the command wins. The pending change is detected on the next IDLE cycle, because the reference is still unchanged.

## Timing
- Reset values:
  - `out_valid`=0, `out_char`=8'h00, `busy`=0, `mon_armed`=0.
  - `cmd_ready`=1 from the first cycle after reset.
  - State is IDLE and the monitor reference is 0.
- Reset mid-stream aborts the stream immediately. No further characters are emitted and the monitor is disarmed.
- Latency: command accepted at edge T gives `out_valid` from T+1. A monitor change seen in IDLE at T gives `out_valid` from T+1.
- Throughput: one character per cycle while `out_ready`=1.
- While `out_valid` && !`out_ready`, `out_char` and `out_valid` hold stable.
- After the last character handshakes at edge E, `cmd_ready`=1 from E+1.
- Stream length: k*D + (k-1) + (1 for display or monitor), where k is the number of enabled channels.

## Structure
- Package `fmt_pkg` holds:
  - enums `fmt_mode_e` and `fmt_radix_e`
  - localparams `CHAR_NL` and `CHAR_0`
  - function `fmt_digits(width, radix)`
- Sub-module `fmt_digit_enc`: combinational map from a 4-bit digit value to ASCII, with a radix input for range checking.
- Top-level contents:
  - FSM
  - channel and digit counters, each $clog2-sized
  - print snapshot and monitor reference registers

## Test plan
- Display, hex, `DATA_W`=32, mask 4'b0101, ch0=32'hDEADBEEF, ch2=32'h1 -> "deadbeef 00000001\n", 18 characters, first `out_valid` at T+1.
- Write, bin, `DATA_W`=8, mask 4'b0001, ch0=8'hA5 -> "10100101", no newline; `cmd_ready` returns one cycle after the last handshake.
- Oct, `DATA_W`=32, ch0=32'hFFFFFFFF -> "37777777777" (11 digits), top digit zero-extended.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-stream -> `out_char` stable throughout; no character lost or duplicated.
- Monitor on ch1, then ch1 changes 5->6 while ch0 toggles unmasked -> exactly two records, "...5\n" then "...6\n". A display command issued in the same cycle as the 5->6 change is printed first. Monitor-off -> no further output.
- `rst_n`=0 for one cycle mid-stream -> `out_valid`=0 the next cycle, `mon_armed`=0, `cmd_ready`=1.

Source files
------------

// File: rtl/fmt_pkg.sv
// Shared types and helpers for the formatted print engine.
package fmt_pkg;

    typedef enum logic [1:0] {
        MODE_DISPLAY = 2'b00,
        MODE_WRITE   = 2'b01,
        MODE_MON_ARM = 2'b10,
        MODE_MON_OFF = 2'b11
    } fmt_mode_e;

    typedef enum logic [1:0] {
        RADIX_HEX     = 2'b00,
        RADIX_BIN     = 2'b01,
        RADIX_OCT     = 2'b10,
        RADIX_HEX_ALT = 2'b11
    } fmt_radix_e;

    localparam logic [7:0] CHAR_NL = 8'h0A;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_A  = 8'h61;

    function automatic int fmt_bits_per_digit(input fmt_radix_e radix);
        case (radix)
            RADIX_BIN: return 1;
            RADIX_OCT: return 3;
            default:   return 4;
        endcase
    endfunction

    function automatic int fmt_digits(input int width, input fmt_radix_e radix);
        int b;
        b = fmt_bits_per_digit(radix);
        return (width + b - 1) / b;
    endfunction

endpackage

// File: rtl/fmt_digit_enc.sv
// Maps one digit value to its ASCII character; the radix trims the value to
// the bits a digit of that radix can actually hold.
module fmt_digit_enc
    import fmt_pkg::*;
(
    input  logic [3:0] value,
    input  fmt_radix_e radix,
    output logic [7:0] ascii
);

    logic [3:0] digit;

    always_comb begin
        case (radix)
            RADIX_BIN: digit = {3'b000, value[0]};
            RADIX_OCT: digit = {1'b0, value[2:0]};
            default:   digit = value;
        endcase
        if (digit < 4'd10)
            ascii = CHAR_0 + {4'b0000, digit};
        else
            ascii = CHAR_A + {4'b0000, digit - 4'd10};
    end

endmodule

// File: rtl/fmt_print_engine.sv
// Renders snapshot channel values as an ASCII byte stream, one record per
// command or per monitored value change.
module fmt_print_engine
    import fmt_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          NUM_CH   = 4,
    parameter logic [7:0]  SEP_CHAR = 8'h20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [1:0]               cmd_radix,
    input  logic [NUM_CH-1:0]        cmd_ch_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_char,
    output logic                     busy,
    output logic                     mon_armed
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIG_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DIGIT, ST_SEP, ST_NL} state_e;

    state_e                   state, state_d;
    logic [CH_W-1:0]          ch_idx, ch_d, next_ch;
    logic [DIG_W-1:0]         dig_idx, dig_d;
    logic [NUM_CH*DATA_W-1:0] snapshot, mon_ref;
    logic [NUM_CH-1:0]        cur_mask, mon_mask, mon_diff;
    fmt_radix_e               cur_radix, mon_radix, cmd_radix_e;
    fmt_mode_e                cmd_mode_e;
    logic                     cur_nl, mon_hit, has_next, accept, trigger;
    logic [DATA_W+3:0]        chan_ext;
    logic [3:0]               digit_val;
    logic [7:0]               digit_char;

    function automatic logic [CH_W-1:0] first_set(input logic [NUM_CH-1:0] m);
        first_set = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) first_set = CH_W'(i);
    endfunction

    function automatic logic [DIG_W-1:0] last_digit(input fmt_radix_e r);
        return DIG_W'(fmt_digits(DATA_W, r) - 1);
    endfunction

    assign cmd_mode_e  = fmt_mode_e'(cmd_mode);
    assign cmd_radix_e = fmt_radix_e'(cmd_radix);
    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign out_valid   = busy;

    // Monitor change detection and lookup of the next enabled channel.
    always_comb begin
        mon_diff = '0;
        has_next = 1'b0;
        next_ch  = '0;
        for (int i = 0; i < NUM_CH; i++)
            mon_diff[i] = (ch_data[i*DATA_W +: DATA_W] != mon_ref[i*DATA_W +: DATA_W]);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cur_mask[i] && (i > int'(ch_idx))) begin
                has_next = 1'b1;
                next_ch  = CH_W'(i);
            end
        end
        mon_hit = mon_armed && (|(mon_diff & mon_mask));
    end

    // The top digit picks up zeros from the 4-bit extension.
    always_comb begin
        chan_ext  = {4'b0000, snapshot[int'(ch_idx)*DATA_W +: DATA_W]};
        digit_val = 4'(chan_ext >> (int'(dig_idx) * fmt_bits_per_digit(cur_radix)));
    end

    fmt_digit_enc u_enc (
        .value (digit_val),
        .radix (cur_radix),
        .ascii (digit_char)
    );

    always_comb begin
        case (state)
            ST_DIGIT: out_char = digit_char;
            ST_SEP:   out_char = SEP_CHAR;
            ST_NL:    out_char = CHAR_NL;
            default:  out_char = 8'h00;
        endcase
    end

    // A user command in IDLE takes priority over a monitor trigger.
    always_comb begin
        state_d = state;
        ch_d    = ch_idx;
        dig_d   = dig_idx;
        accept  = 1'b0;
        trigger = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_mode_e != MODE_MON_OFF) begin
                        if (|cmd_ch_mask) begin
                            state_d = ST_DIGIT;
                            ch_d    = first_set(cmd_ch_mask);
                            dig_d   = last_digit(cmd_radix_e);
                        end else if (cmd_mode_e != MODE_WRITE) begin
                            state_d = ST_NL;
                        end
                    end
                end else if (mon_hit) begin
                    trigger = 1'b1;
                    state_d = ST_DIGIT;
                    ch_d    = first_set(mon_mask);
                    dig_d   = last_digit(mon_radix);
                end
            end
            ST_DIGIT: begin
                if (out_ready) begin
                    if (dig_idx == '0) begin
                        if (has_next)    state_d = ST_SEP;
                        else if (cur_nl) state_d = ST_NL;
                        else             state_d = ST_IDLE;
                    end else begin
                        dig_d = dig_idx - 1'b1;
                    end
                end
            end
            ST_SEP: begin
                if (out_ready) begin
                    state_d = ST_DIGIT;
                    ch_d    = next_ch;
                    dig_d   = last_digit(cur_radix);
                end
            end
            ST_NL: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ch_idx  <= '0;
            dig_idx <= '0;
        end else begin
            state   <= state_d;
            ch_idx  <= ch_d;
            dig_idx <= dig_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snapshot  <= '0;
            mon_ref   <= '0;
            cur_mask  <= '0;
            cur_radix <= RADIX_HEX;
            cur_nl    <= 1'b0;
            mon_mask  <= '0;
            mon_radix <= RADIX_HEX;
            mon_armed <= 1'b0;
        end else if (accept) begin
            if (cmd_mode_e == MODE_MON_OFF) begin
                mon_armed <= 1'b0;
            end else begin
                snapshot  <= ch_data;
                cur_mask  <= cmd_ch_mask;
                cur_radix <= cmd_radix_e;
                cur_nl    <= (cmd_mode_e != MODE_WRITE);
                if (cmd_mode_e == MODE_MON_ARM) begin
                    mon_armed <= 1'b1;
                    mon_mask  <= cmd_ch_mask;
                    mon_radix <= cmd_radix_e;
                    mon_ref   <= ch_data;
                end
            end
        end else if (trigger) begin
            snapshot  <= ch_data;
            mon_ref   <= ch_data;
            cur_mask  <= mon_mask;
            cur_radix <= mon_radix;
            cur_nl    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fmt_print_engine.sv
// Scoreboard bench for fmt_print_engine: expected characters are queued when a
// command is issued and compared as each character handshakes.
module tb_fmt_print_engine;

    logic         clk;
    logic         rst_n;
    logic [127:0] ch_data;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_mode;
    logic [1:0]   cmd_radix;
    logic [3:0]   cmd_ch_mask;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_char;
    logic         busy;
    logic         mon_armed;

    int errors = 0;
    int checks = 0;
    int rx_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_char;

    fmt_print_engine #(.DATA_W(32), .NUM_CH(4), .SEP_CHAR(8'h20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_data     (ch_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_radix   (cmd_radix),
        .cmd_ch_mask (cmd_ch_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char),
        .busy        (busy),
        .mon_armed   (mon_armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs settle 1 time unit after posedge, so the negedge sees what the
    // next posedge will use.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            rx_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_char got=%h expected none", out_char);
            end else begin
                exp_char = exp_q.pop_front();
                if (out_char !== exp_char) begin
                    errors++;
                    $display("[TB] FAIL stream_char got=%h expected=%h", out_char, exp_char);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_chan(input logic [31:0] v, input logic [1:0] radix);
        int b;
        int n;
        logic [63:0] w;
        int dig;
        b = (radix == 2'b01) ? 1 : (radix == 2'b10) ? 3 : 4;
        n = (32 + b - 1) / b;
        for (int d = n - 1; d >= 0; d--) begin
            w   = {32'h0, v} >> (d * b);
            dig = int'(w & ((64'd1 << b) - 64'd1));
            if (dig < 10) exp_q.push_back(8'(8'h30 + dig));
            else          exp_q.push_back(8'(8'h61 + dig - 10));
        end
    endtask

    task automatic push_record(input logic [1:0] radix, input logic [3:0] mask, input bit nl);
        bit first;
        first = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                if (!first) exp_q.push_back(8'h20);
                push_chan(ch_data[c*32 +: 32], radix);
                first = 1'b0;
            end
        end
        if (nl) exp_q.push_back(8'h0A);
    endtask

    task automatic set_ch(input int idx, input logic [31:0] v);
        ch_data[idx*32 +: 32] = v;
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic [1:0] radix, input logic [3:0] mask);
        cmd_valid   = 1'b1;
        cmd_mode    = mode;
        cmd_radix   = radix;
        cmd_ch_mask = mask;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b expected=0", out_valid); end
        checks++;
        if (out_char !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_char got=%h expected=00", out_char); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b expected=0", busy); end
        checks++;
        if (mon_armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_mon_armed got=%b expected=0", mon_armed); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got=%b expected=1", cmd_ready); end
    endtask

    task automatic test_display_hex();
        bit ok;
        int start;
        ch_data = '0;
        set_ch(0, 32'hDEADBEEF);
        set_ch(2, 32'h00000001);
        set_ch(1, 32'h12345678);
        push_str("deadbeef 00000001\n");
        start = rx_count;
        send_cmd(2'b00, 2'b00, 4'b0101);
        set_ch(0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_char !== 8'h64) begin
            errors++;
            $display("[TB] FAIL display_latency got=%b/%h expected=1/64", out_valid, out_char);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL display_drain got=%0d left expected=0", exp_q.size()); end
        checks++;
        if (rx_count - start !== 18) begin errors++; $display("[TB] FAIL display_length got=%0d expected=18", rx_count - start); end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL display_idle got=%b/%b expected=1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_bin();
        bit ok;
        int start;
        ch_data = '0;
        set_ch(0, 32'h000000A5);
        push_str("000000000000000000000000");
        push_str("10100101");
        start = rx_count;
        send_cmd(2'b01, 2'b01, 4'b0001);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL write_drain got=%0d left expected=0", exp_q.size()); end
        checks++;
        if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_ready_after_last got=%b/%b expected=1/0", cmd_ready, out_valid);
        end
        checks++;
        if (rx_count - start !== 32) begin errors++; $display("[TB] FAIL write_length got=%0d expected=32", rx_count - start); end
    endtask

    task automatic test_oct();
        bit ok;
        ch_data = '0;
        set_ch(0, 32'hFFFFFFFF);
        push_str("37777777777\n");
        send_cmd(2'b00, 2'b10, 4'b0001);
        wait_drain(ok);
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oct_drain got=%0d left busy=%b expected=0 left busy=0", exp_q.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int start;
        logic [7:0] held;
        for (int c = 0; c < 4; c++) set_ch(c, $urandom);
        push_record(2'b11, 4'b1111, 1'b1);
        start = rx_count;
        send_cmd(2'b00, 2'b11, 4'b1111);
        idle_cycles(3);
        out_ready = 1'b0;
        held = out_char;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_char !== held) begin
                errors++;
                $display("[TB] FAIL backpressure_hold got=%b/%h expected=1/%h", out_valid, out_char, held);
            end
        end
        out_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || rx_count - start !== 36) begin
            errors++;
            $display("[TB] FAIL backpressure_length got=%0d expected=36", rx_count - start);
        end
    endtask

    task automatic test_zero_mask();
        bit ok;
        int start;
        push_str("\n");
        send_cmd(2'b00, 2'b00, 4'b0000);
        wait_drain(ok);
        checks++;
        if (!ok || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_display got=%0d left expected=0", exp_q.size()); end
        start = rx_count;
        send_cmd(2'b01, 2'b00, 4'b0000);
        idle_cycles(3);
        checks++;
        if (rx_count !== start || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_write got=%0d chars busy=%b expected=0 chars busy=0", rx_count - start, busy);
        end
    endtask

    task automatic test_monitor();
        bit ok;
        int start;
        ch_data = '0;
        set_ch(1, 32'h5);
        push_str("00000005\n");
        send_cmd(2'b10, 2'b00, 4'b0010);
        checks++;
        if (mon_armed !== 1'b1) begin errors++; $display("[TB] FAIL monitor_armed got=%b expected=1", mon_armed); end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL monitor_first got=%0d left expected=0", exp_q.size()); end
        start = rx_count;
        for (int i = 1; i <= 6; i++) begin
            set_ch(0, 32'(i));
            @(posedge clk); #1;
        end
        checks++;
        if (rx_count !== start || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL monitor_unmasked got=%0d chars expected=0", rx_count - start);
        end
        set_ch(0, 32'h0000ABCD);
        set_ch(1, 32'h6);
        push_str("0000abcd\n");
        push_str("00000006\n");
        send_cmd(2'b00, 2'b00, 4'b0001);
        wait_drain(ok);
        checks++;
        if (!ok || rx_count - start !== 18) begin
            errors++;
            $display("[TB] FAIL monitor_collision got=%0d chars expected=18", rx_count - start);
        end
        send_cmd(2'b11, 2'b00, 4'b0000);
        checks++;
        if (mon_armed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL monitor_off got=%b/%b expected=0/0", mon_armed, busy);
        end
        start = rx_count;
        set_ch(1, 32'h7);
        idle_cycles(10);
        checks++;
        if (rx_count !== start) begin errors++; $display("[TB] FAIL monitor_silent got=%0d chars expected=0", rx_count - start); end
    endtask

    task automatic test_reset_mid();
        int start;
        for (int c = 0; c < 4; c++) set_ch(c, $urandom);
        push_record(2'b00, 4'b1111, 1'b1);
        send_cmd(2'b10, 2'b00, 4'b1111);
        idle_cycles(5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || mon_armed !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid got=%b/%b/%b expected=0/0/1", out_valid, mon_armed, cmd_ready);
        end
        exp_q.delete();
        rst_n = 1'b1;
        start = rx_count;
        set_ch(0, ~ch_data[31:0]);
        idle_cycles(10);
        checks++;
        if (rx_count !== start || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_silent got=%0d chars expected=0", rx_count - start);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ch_data     = '0;
        cmd_valid   = 1'b0;
        cmd_mode    = 2'b00;
        cmd_radix   = 2'b00;
        cmd_ch_mask = 4'b0000;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_display_hex();
        test_write_bin();
        test_oct();
        test_backpressure();
        test_zero_mask();
        test_monitor();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
